alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Sits directly downstream of the 16-bit ALU in the datapath. It captures the ALU result, zero flag, ovfl flag, op code and destination register index, and buffers them in a small FIFO.
- It presents the buffered entries to writeback using a valid/ready handshake.
- Signed-arithmetic overflow (ADD/SUB with ovfl=1) raises a trap. The trapping result is dropped from writeback and recorded in trap status registers.

Parameters:
- WIDTH, 16, datapath width of ALU result.
- DEPTH, 2, FIFO entries; must be a power of two and at least 2.
- CNT_W, 8, width of the saturating trap counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept an entry.
- in_r  input  WIDTH  ALU result r.
- in_zero  input  1  ALU zero flag.
- in_ovfl  input  1  ALU overflow flag.
- in_op  input  3  ALU op (0 AND, 1 OR, 2 NOR, 3 ADD, 4 SUB, 5 SLT).
- in_dest  input  3  destination register index.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts the head entry.
- out_r  output  WIDTH  head result.
- out_zero  output  1  head zero flag.
- out_dest  output  3  head destination register index.
- trap_pulse  output  1  one-cycle pulse when a trapping entry is accepted.
- trap_sticky  output  1  set by a trap; cleared by trap_clr.
- trap_r  output  WIDTH  result of the most recent trap.
- trap_dest  output  3  destination register of the most recent trap.
- trap_cnt  output  CNT_W  saturating count of traps.
- trap_clr  input  1  clears trap_sticky.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO is emptied.
  - out_valid=0, out_r=0, out_zero=0, out_dest=0.
  - trap_pulse=0, trap_sticky=0, trap_r=0, trap_dest=0, trap_cnt=0.
  - in_ready=0 while reset is asserted. After release, in_ready=1 from the first clock edge.
  - Reset asserted mid-operation discards all entries and trap state immediately.
- Handshake:
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = !full. It is registered from the occupancy count, so it does not depend combinationally on out_ready.
  - When full, a pop in that cycle does not permit a same-cycle push.
  - When neither full nor empty, a simultaneous push and pop leaves the count unchanged.
  - out_* are driven from the FIFO head. They are held stable while out_valid=1 and out_ready=0.
- Latency: an entry accepted at edge N appears on out_* after edge N, i.e. one cycle. There is no combinational in-to-out bypass.
- Trap classification:
  - trap = accept & in_ovfl & (in_op==3 | in_op==4).
  - A trapping entry is not enqueued.
  - On a trap: trap_pulse=1 for the next cycle only, trap_sticky<=1, trap_r<=in_r, trap_dest<=in_dest, trap_cnt<=trap_cnt+1. trap_cnt saturates at all-ones with no wrap.
  - in_ovfl on any op other than ADD or SUB is ignored, and the entry is enqueued normally.
- trap_clr and a trap in the same cycle: the set wins, so trap_sticky stays 1.
- SLT entries: bits [WIDTH-1:1] of out_r are forced to 0 on enqueue.
- Pointers: read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = MSBs differ and the remaining bits are equal.
  - empty = pointers equal.

Optional Feature:
- Macro ALU_OVFL_TRAP_EN.
- Defined: trap behaviour exactly as specified above.
- Undefined:
  - Every accepted entry is enqueued, including overflowing ADD/SUB results.
  - trap_pulse, trap_sticky, trap_r, trap_dest and trap_cnt are constant 0.
  - trap_clr is ignored.

Decomposition:
- Shared package alu_pkg holds:
  - op constants OP_AND=3'd0, OP_OR=3'd1, OP_NOR=3'd2, OP_ADD=3'd3, OP_SUB=3'd4, OP_SLT=3'd5;
  - ALU_W=16 and REG_IDX_W=3;
  - the FIFO entry struct {r, zero, dest}.
- One sub-module, result_fifo, parameterised by DEPTH and entry width. It owns the pointers, the full/empty logic and the storage.
- The top level holds trap classification, the trap registers and the SLT masking.

Test Plan:
- Reset, then ADD entry in_r=24bf, ovfl=0, dest=2, out_ready=1 -> out_valid=1 one cycle later, out_r=24bf, out_dest=2; out_valid=0 the cycle after.
- out_ready=0, push SUB 000f then AND 4a12 -> in_ready=0 after the second push. A third in_valid is not accepted. Then raise out_ready -> 000f pops, then 4a12, in order.
- ADD in_r=8000, ovfl=1, dest=5 -> no out_valid; trap_pulse=1 for exactly one cycle; trap_sticky=1, trap_r=8000, trap_dest=5, trap_cnt=1.
- trap_clr=1 in the same cycle as a SUB trap with in_r=8000 -> trap_sticky remains 1 and trap_cnt increments. trap_clr alone on the next cycle -> trap_sticky=0 and trap_cnt is unchanged.
- OR with in_ovfl=1, in_r=dbf7 -> enqueued normally with no trap. SLT with in_r=ffff -> out_r=0001.
- Assert rst_n=0 with 2 entries queued and trap_sticky=1 -> immediately out_valid=0, trap_sticky=0, trap_cnt=0. Sweep 260 traps -> trap_cnt saturates at ff.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: op codes, widths and the result FIFO entry.
package alu_pkg;

    localparam int ALU_W     = 16;
    localparam int REG_IDX_W = 3;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_NOR = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;

    typedef struct packed {
        logic [ALU_W-1:0]     r;
        logic                 zero;
        logic [REG_IDX_W-1:0] dest;
    } fifo_entry_t;

    // Only signed add/subtract can raise an overflow trap.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Small power-of-two FIFO with wrap-bit pointers and a registered ready flag.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int EW    = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] wdata,
    output logic [EW-1:0] rdata,
    output logic          empty,
    output logic          ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr_nxt;
    logic [PW-1:0] rptr_nxt;
    logic          full;
    logic          full_nxt;
    logic          push_ok;
    logic          pop_ok;

    assign empty    = (wptr == rptr);
    assign full     = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign wptr_nxt = wptr + {{(PW-1){1'b0}}, push_ok};
    assign rptr_nxt = rptr + {{(PW-1){1'b0}}, pop_ok};
    assign full_nxt = (wptr_nxt[PW-1] != rptr_nxt[PW-1]) &&
                      (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);

    // The head reads as zero whenever nothing is queued.
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            ready <= 1'b0;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            ready <= !full_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result buffer with valid/ready writeback and overflow trapping.
// Trapping is enabled by defining ALU_OVFL_TRAP_EN; otherwise every entry is queued.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_r,
    input  logic                 in_zero,
    input  logic                 in_ovfl,
    input  logic [2:0]           in_op,
    input  logic [REG_IDX_W-1:0] in_dest,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_r,
    output logic                 out_zero,
    output logic [REG_IDX_W-1:0] out_dest,
    output logic                 trap_pulse,
    output logic                 trap_sticky,
    output logic [WIDTH-1:0]     trap_r,
    output logic [REG_IDX_W-1:0] trap_dest,
    output logic [CNT_W-1:0]     trap_cnt,
    input  logic                 trap_clr
);

    localparam int EW = WIDTH + 1 + REG_IDX_W;

    logic             accept;
    logic             pop;
    logic             push;
    logic             trap;
    logic             fifo_empty;
    logic [WIDTH-1:0] r_masked;
    logic [EW-1:0]    wdata;
    logic [EW-1:0]    rdata;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;
    assign push   = accept && !trap;

    // SLT only produces a boolean, so everything above bit 0 is cleared.
    assign r_masked = (in_op == OP_SLT) ? {{(WIDTH-1){1'b0}}, in_r[0]} : in_r;
    assign wdata    = {r_masked, in_zero, in_dest};

    result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .empty (fifo_empty),
        .ready (in_ready)
    );

    assign out_valid                    = !fifo_empty;
    assign {out_r, out_zero, out_dest}  = rdata;

`ifdef ALU_OVFL_TRAP_EN
    assign trap = accept && in_ovfl && is_arith(in_op);

    // A trap in the same cycle as trap_clr keeps the sticky bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_pulse  <= 1'b0;
            trap_sticky <= 1'b0;
            trap_r      <= '0;
            trap_dest   <= '0;
            trap_cnt    <= '0;
        end else begin
            trap_pulse <= trap;
            if (trap) begin
                trap_sticky <= 1'b1;
                trap_r      <= in_r;
                trap_dest   <= in_dest;
                if (trap_cnt != {CNT_W{1'b1}}) begin
                    trap_cnt <= trap_cnt + CNT_W'(1);
                end
            end else if (trap_clr) begin
                trap_sticky <= 1'b0;
            end
        end
    end
`else
    logic unused_trap_inputs;

    assign trap               = 1'b0;
    assign trap_pulse         = 1'b0;
    assign trap_sticky        = 1'b0;
    assign trap_r             = '0;
    assign trap_dest          = '0;
    assign trap_cnt           = '0;
    assign unused_trap_inputs = &{1'b0, in_ovfl, trap_clr};
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic against a queue model.
module tb_alu_result_stage;

    localparam int  DEPTH   = 2;
    localparam int  CNT_MAX = 255;
`ifdef ALU_OVFL_TRAP_EN
    localparam bit  TRAP_EN = 1'b1;
`else
    localparam bit  TRAP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_r;
    logic        in_zero;
    logic        in_ovfl;
    logic [2:0]  in_op;
    logic [2:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_r;
    logic        out_zero;
    logic [2:0]  out_dest;
    logic        trap_pulse;
    logic        trap_sticky;
    logic [15:0] trap_r;
    logic [2:0]  trap_dest;
    logic [7:0]  trap_cnt;
    logic        trap_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic [2:0]  d;
    } ent_t;

    ent_t        exp_q[$];
    bit          m_armed;
    bit          m_pulse;
    bit          m_sticky;
    logic [15:0] m_tr;
    logic [2:0]  m_td;
    int          m_cnt;

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_r        (in_r),
        .in_zero     (in_zero),
        .in_ovfl     (in_ovfl),
        .in_op       (in_op),
        .in_dest     (in_dest),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_zero    (out_zero),
        .out_dest    (out_dest),
        .trap_pulse  (trap_pulse),
        .trap_sticky (trap_sticky),
        .trap_r      (trap_r),
        .trap_dest   (trap_dest),
        .trap_cnt    (trap_cnt),
        .trap_clr    (trap_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        return m_armed && (exp_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_armed  = 1'b0;
        m_pulse  = 1'b0;
        m_sticky = 1'b0;
        m_tr     = '0;
        m_td     = '0;
        m_cnt    = 0;
    endtask

    task automatic set_in(input bit v, input logic [2:0] op, input logic [15:0] r,
                          input bit z, input bit ov, input logic [2:0] d);
        in_valid = v;
        in_op    = op;
        in_r     = r;
        in_zero  = z;
        in_ovfl  = ov;
        in_dest  = d;
    endtask

    // One clock of the reference model; outputs are sampled 1 time unit after the edge.
    task automatic step();
        bit   acc;
        bit   pp;
        bit   tr;
        ent_t e;
        acc = in_valid && m_ready();
        pp  = (exp_q.size() > 0) && out_ready;
        tr  = TRAP_EN && acc && in_ovfl && (in_op == 3'd3 || in_op == 3'd4);
        e.r = (in_op == 3'd5) ? {15'd0, in_r[0]} : in_r;
        e.z = in_zero;
        e.d = in_dest;
        @(posedge clk);
        if (pp) void'(exp_q.pop_front());
        if (acc && !tr) exp_q.push_back(e);
        m_pulse = tr;
        if (tr) begin
            m_sticky = 1'b1;
            m_tr     = in_r;
            m_td     = in_dest;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else if (TRAP_EN && trap_clr) begin
            m_sticky = 1'b0;
        end
        m_armed = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        out_ready = 1'b0;
        trap_clr  = 1'b0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++; if ({out_r, out_zero, out_dest} !== 20'h0) begin errors++; $display("[TB] FAIL reset_out_data: got %h want 0", {out_r, out_zero, out_dest}); end
        checks++; if ({trap_pulse, trap_sticky, trap_r, trap_dest, trap_cnt} !== 29'h0) begin errors++; $display("[TB] FAIL reset_trap_state: got %h want 0", {trap_pulse, trap_sticky, trap_r, trap_dest, trap_cnt}); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_release: got %b want 1", in_ready); end
    endtask

    task automatic test_single_add();
        out_ready = 1'b1;
        set_in(1, 3'd3, 16'h24bf, 0, 0, 3'd2);
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %b want 1", out_valid); end
        checks++; if (out_r !== 16'h24bf) begin errors++; $display("[TB] FAIL add_r: got %h want 24bf", out_r); end
        checks++; if (out_dest !== 3'd2) begin errors++; $display("[TB] FAIL add_dest: got %0d want 2", out_dest); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_in(1, 3'd4, 16'h000f, 1, 0, 3'd1);
        step();
        set_in(1, 3'd0, 16'h4a12, 0, 0, 3'd3);
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_in_ready: got %b want 0", in_ready); end
        set_in(1, 3'd1, 16'h1234, 0, 0, 3'd4);
        step();
        checks++; if (out_r !== 16'h000f) begin errors++; $display("[TB] FAIL held_head: got %h want 000f", out_r); end
        // Popping while full must not let this cycle's push in.
        out_ready = 1'b1;
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (out_r !== 16'h4a12 || out_dest !== 3'd3) begin errors++; $display("[TB] FAIL second_pop: got %h/%0d want 4a12/3", out_r, out_dest); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_no_push: got valid %b want 0", out_valid); end
    endtask

    task automatic test_trap();
        out_ready = 1'b1;
        trap_clr  = 1'b0;
        set_in(1, 3'd3, 16'h8000, 0, 1, 3'd5);
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (out_valid !== !TRAP_EN) begin errors++; $display("[TB] FAIL trap_dropped: got valid %b want %b", out_valid, !TRAP_EN); end
        checks++; if (trap_pulse !== TRAP_EN || trap_sticky !== TRAP_EN) begin errors++; $display("[TB] FAIL trap_flags: got %b%b want %b%b", trap_pulse, trap_sticky, TRAP_EN, TRAP_EN); end
        checks++; if (trap_r !== (TRAP_EN ? 16'h8000 : 16'h0) || trap_dest !== (TRAP_EN ? 3'd5 : 3'd0)) begin errors++; $display("[TB] FAIL trap_record: got %h/%0d", trap_r, trap_dest); end
        checks++; if (trap_cnt !== (TRAP_EN ? 8'd1 : 8'd0)) begin errors++; $display("[TB] FAIL trap_cnt1: got %0d want %0d", trap_cnt, TRAP_EN); end
        step();
        checks++; if (trap_pulse !== 1'b0) begin errors++; $display("[TB] FAIL trap_pulse_width: got %b want 0", trap_pulse); end
        set_in(1, 3'd4, 16'h8000, 0, 1, 3'd6);
        trap_clr = 1'b1;
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (trap_sticky !== TRAP_EN || trap_cnt !== (TRAP_EN ? 8'd2 : 8'd0)) begin errors++; $display("[TB] FAIL clr_vs_set: got %b/%0d", trap_sticky, trap_cnt); end
        step();
        trap_clr = 1'b0;
        checks++; if (trap_sticky !== 1'b0 || trap_cnt !== (TRAP_EN ? 8'd2 : 8'd0)) begin errors++; $display("[TB] FAIL clr_alone: got %b/%0d", trap_sticky, trap_cnt); end
        step();
    endtask

    task automatic test_non_trap_ops();
        out_ready = 1'b1;
        set_in(1, 3'd1, 16'hdbf7, 0, 1, 3'd7);
        step();
        set_in(1, 3'd5, 16'hffff, 0, 0, 3'd4);
        checks++; if (out_valid !== 1'b1 || out_r !== 16'hdbf7 || trap_pulse !== 1'b0) begin errors++; $display("[TB] FAIL or_ovfl: got %b/%h/%b want 1/dbf7/0", out_valid, out_r, trap_pulse); end
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (out_r !== 16'h0001 || out_dest !== 3'd4) begin errors++; $display("[TB] FAIL slt_mask: got %h/%0d want 0001/4", out_r, out_dest); end
        step();
    endtask

    task automatic test_midop_reset();
        out_ready = 1'b0;
        set_in(1, 3'd3, 16'h7fff, 0, 1, 3'd1);
        step();
        set_in(1, 3'd0, 16'h1111, 0, 0, 3'd2);
        step();
        set_in(1, 3'd1, 16'h2222, 0, 0, 3'd3);
        step();
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        checks++; if (out_valid !== 1'b1 || trap_sticky !== TRAP_EN) begin errors++; $display("[TB] FAIL pre_reset_state: got %b/%b", out_valid, trap_sticky); end
        #2;
        do_reset();
        checks++; if (out_valid !== 1'b0 || trap_sticky !== 1'b0 || trap_cnt !== 8'd0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midop_reset: got v%b s%b c%0d r%b", out_valid, trap_sticky, trap_cnt, in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            set_in(1, (i % 2 == 0) ? 3'd3 : 3'd4, 16'(i), 0, 1, 3'(i));
            step();
        end
        set_in(0, 3'd0, 16'h0, 0, 0, 3'd0);
        step();
        checks++; if (trap_cnt !== (TRAP_EN ? 8'hff : 8'h00)) begin errors++; $display("[TB] FAIL cnt_saturate: got %h want %h", trap_cnt, TRAP_EN ? 8'hff : 8'h00); end
        do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_random();
        int bad;
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                   1'($urandom), $urandom_range(0, 3) == 0, 3'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            trap_clr  = $urandom_range(0, 9) == 0;
            step();
            bad = 0;
            checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== m_ready()) bad = 1;
            if (exp_q.size() > 0 && (out_r !== exp_q[0].r || out_zero !== exp_q[0].z || out_dest !== exp_q[0].d)) bad = 1;
            if (trap_pulse !== m_pulse || trap_sticky !== m_sticky || trap_r !== m_tr || trap_dest !== m_td || trap_cnt !== 8'(m_cnt)) bad = 1;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL random_cycle_%0d: got v%b rdy%b r%h z%b d%0d tp%b ts%b tr%h td%0d tc%0d want v%b rdy%b tp%b ts%b tr%h td%0d tc%0d head %h/%b/%0d",
                         i, out_valid, in_ready, out_r, out_zero, out_dest, trap_pulse, trap_sticky, trap_r, trap_dest, trap_cnt,
                         exp_q.size() > 0, m_ready(), m_pulse, m_sticky, m_tr, m_td, m_cnt,
                         exp_q.size() > 0 ? exp_q[0].r : 16'h0, exp_q.size() > 0 ? exp_q[0].z : 1'b0, exp_q.size() > 0 ? exp_q[0].d : 3'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_trap();
        test_non_trap_ops();
        test_midop_reset();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
